// File: rtl/uart_baud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_pkg
// Brief    : Shared state encoding and widths for the UART baud controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_baud_pkg;

   localparam int FRAC_W             = 4;
   localparam int OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } baud_state_t;

   function automatic int os_cnt_width(input int oversample);
      return (oversample > 1) ? $clog2(oversample) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/baud_period_counter.sv
`default_nettype none
// ============================================================================
// Module   : baud_period_counter
// Brief    : Counts one oversample period of div+1 cycles (div+2 after a
//            fractional carry when UART_BAUD_FRAC_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module baud_period_counter
   import uart_baud_pkg::*;
#(
   parameter int DIV_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              run,
   input  logic [DIV_W-1:0]  div,
   input  logic [FRAC_W-1:0] frac,
   output logic              rx_tick
);

   logic [DIV_W:0] r_cnt;
   logic [DIV_W:0] w_period_end;

   // Combinational strobe: the owner registers it alongside the bit strobe
   // so both outputs leave on the same edge.
   assign rx_tick = run && (r_cnt == w_period_end);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else if (run) begin
         if (rx_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] r_frac_acc;
   logic              r_carry;
   logic [FRAC_W:0]   w_acc_sum;

   assign w_acc_sum    = {1'b0, r_frac_acc} + {1'b0, frac};
   assign w_period_end = {1'b0, div} + {{DIV_W{1'b0}}, r_carry};

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_frac_acc <= '0;
         r_carry    <= 1'b0;
      end else if (run && rx_tick) begin
         r_frac_acc <= w_acc_sum[FRAC_W-1:0];
         r_carry    <= w_acc_sum[FRAC_W];
      end
   end
`else
   logic w_unused_frac;

   assign w_unused_frac = ^frac;
   assign w_period_end  = {1'b0, div};
`endif

endmodule
`default_nettype wire

// File: rtl/uart_baud_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_controller
// Brief    : UART prescaler with handshaked divisor updates applied only on a
//            tx bit boundary. Define UART_BAUD_FRAC_EN for fractional divisor.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_controller
   import uart_baud_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int DEFAULT_DIV = 26
)(
   input  logic              fast_clock,
   input  logic              rst,
   input  logic              enable,
   input  logic [DIV_W-1:0]  div_value,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_valid,
   output logic              div_ready,
   output logic              rx_tick,
   output logic              tx_tick,
   output logic              busy
);

   localparam int              OS_W          = os_cnt_width(OVERSAMPLE);
   localparam logic [OS_W-1:0]  C_OS_LAST     = OS_W'(OVERSAMPLE - 1);
   localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);

   baud_state_t       r_state;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  r_shadow_div;
   logic [OS_W-1:0]   r_os_cnt;
   logic [FRAC_W-1:0] w_frac;

   logic w_accept;
   logic w_running;
   logic w_hit;
   logic w_tx;
   logic w_clear;
   logic w_load_direct;
   logic w_capture;
   logic w_take_shadow;

   assign w_accept  = div_valid && div_ready;
   assign w_running = enable && (r_state != IDLE);
   assign w_tx      = w_hit && (r_os_cnt == C_OS_LAST);

   // Outside RUN/PENDING with enable high, a divisor lands in r_div directly;
   // while running it waits in the shadow for the next bit boundary.
   assign w_load_direct = w_accept && ((r_state == IDLE) || ((r_state == RUN) && !enable));
   assign w_capture     = w_accept && (r_state == RUN) && enable;
   assign w_take_shadow = (r_state == PENDING) && (!enable || w_tx);
   assign w_clear       = !w_running || ((r_state == PENDING) && w_tx);

   baud_period_counter #(
      .DIV_W (DIV_W)
   ) u_period (
      .clk     (fast_clock),
      .rst     (rst),
      .clear   (w_clear),
      .run     (w_running),
      .div     (r_div),
      .frac    (w_frac),
      .rx_tick (w_hit)
   );

   always_ff @(posedge fast_clock) begin
      if (rst) begin
         r_state      <= IDLE;
         r_div        <= C_DEFAULT_DIV;
         r_shadow_div <= '0;
         r_os_cnt     <= '0;
         rx_tick      <= 1'b0;
         tx_tick      <= 1'b0;
         busy         <= 1'b0;
         div_ready    <= 1'b1;
      end else begin
         rx_tick <= w_hit;
         tx_tick <= w_tx;

         if (w_clear) begin
            r_os_cnt <= '0;
         end else if (w_hit) begin
            r_os_cnt <= w_tx ? '0 : r_os_cnt + 1'b1;
         end

         if (w_load_direct) begin
            r_div <= div_value;
         end else if (w_take_shadow) begin
            r_div <= r_shadow_div;
         end

         if (w_capture) begin
            r_shadow_div <= div_value;
         end

         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= RUN;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else if (w_accept) begin
                  r_state   <= PENDING;
                  div_ready <= 1'b0;
               end
            end
            PENDING: begin
               if (!enable) begin
                  r_state   <= IDLE;
                  busy      <= 1'b0;
                  div_ready <= 1'b1;
               end else if (w_tx) begin
                  r_state   <= RUN;
                  div_ready <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               busy      <= 1'b0;
               div_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] r_frac;
   logic [FRAC_W-1:0] r_shadow_frac;

   assign w_frac = r_frac;

   always_ff @(posedge fast_clock) begin
      if (rst) begin
         r_frac        <= '0;
         r_shadow_frac <= '0;
      end else begin
         if (w_load_direct) begin
            r_frac <= div_frac;
         end else if (w_take_shadow) begin
            r_frac <= r_shadow_frac;
         end
         if (w_capture) begin
            r_shadow_frac <= div_frac;
         end
      end
   end
`else
   logic w_unused_div_frac;

   assign w_unused_div_frac = ^div_frac;
   assign w_frac            = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baud_controller
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a behavioural period/tick model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baud_controller;

   localparam int DIV_W   = 16;
   localparam int OS      = 16;
   localparam int DEF_DIV = 26;
`ifdef UART_BAUD_FRAC_EN
   localparam int EXP_FRAC_SPAN = 168;
`else
   localparam int EXP_FRAC_SPAN = 160;
`endif

   logic             fast_clock = 1'b0;
   logic             rst;
   logic             enable;
   logic             div_valid;
   logic [DIV_W-1:0] div_value;
   logic [3:0]       div_frac;
   logic             div_ready;
   logic             rx_tick;
   logic             tx_tick;
   logic             busy;

   uart_baud_controller #(
      .DIV_W       (DIV_W),
      .OVERSAMPLE  (OS),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .fast_clock (fast_clock),
      .rst        (rst),
      .enable     (enable),
      .div_value  (div_value),
      .div_frac   (div_frac),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .rx_tick    (rx_tick),
      .tx_tick    (tx_tick),
      .busy       (busy)
   );

   always #5 fast_clock = ~fast_clock;

   // ctl = {rst, enable, div_valid}; exp = {rx_tick, tx_tick, busy, div_ready}
   typedef struct {
      logic [2:0]  ctl;
      logic [15:0] dv;
      logic [3:0]  exp;
   } vec_t;

   vec_t tbl [16];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Behavioural model: time elapsed in the current rx period, ticks in bit.
   bit m_running, m_pending;
   int m_div, m_frac, m_sh_div, m_sh_frac;
   int m_elapsed, m_ticks, m_acc, m_extra;
   bit e_rx, e_tx, e_busy, e_ready;

   function automatic int frac_in();
`ifdef UART_BAUD_FRAC_EN
      return int'(div_frac);
`else
      return 0;
`endif
   endfunction

   task automatic model_restart();
      m_elapsed = 0;
      m_ticks   = 0;
      m_acc     = 0;
      m_extra   = 0;
   endtask

   task automatic model_step();
      bit accept;
      accept = div_valid && !m_pending;
      e_rx   = 1'b0;
      e_tx   = 1'b0;
      if (rst) begin
         m_running = 1'b0;
         m_pending = 1'b0;
         m_div     = DEF_DIV;
         m_frac    = 0;
      end else if (!m_running) begin
         if (accept) begin
            m_div  = int'(div_value);
            m_frac = frac_in();
         end
         if (enable) begin
            m_running = 1'b1;
            model_restart();
         end
      end else if (!enable) begin
         if (m_pending) begin
            m_div  = m_sh_div;
            m_frac = m_sh_frac;
         end else if (accept) begin
            m_div  = int'(div_value);
            m_frac = frac_in();
         end
         m_running = 1'b0;
         m_pending = 1'b0;
      end else begin
         m_elapsed++;
         if (m_elapsed == m_div + 1 + m_extra) begin
            e_rx      = 1'b1;
            m_elapsed = 0;
            m_acc     = m_acc + m_frac;
            m_extra   = m_acc / 16;
            m_acc     = m_acc % 16;
            m_ticks++;
            if (m_ticks == OS) begin
               e_tx    = 1'b1;
               m_ticks = 0;
            end
         end
         if (!m_pending && accept) begin
            m_sh_div  = int'(div_value);
            m_sh_frac = frac_in();
            m_pending = 1'b1;
         end else if (m_pending && e_tx) begin
            m_div     = m_sh_div;
            m_frac    = m_sh_frac;
            m_pending = 1'b0;
            model_restart();
         end
      end
      e_busy  = m_running;
      e_ready = !m_pending;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge fast_clock);
      model_step();
      cyc++;
      #1;
      check_bit("model_rx_tick", rx_tick, e_rx);
      check_bit("model_tx_tick", tx_tick, e_tx);
      check_bit("model_busy", busy, e_busy);
      check_bit("model_div_ready", div_ready, e_ready);
   endtask

   task automatic run_until(input bit want_tx, input int bound, output int n);
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < bound) begin
         cycle();
         n++;
         seen = want_tx ? tx_tick : rx_tick;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL wait_%s cycle=%0d got=none expected=strobe within %0d cycles",
                  want_tx ? "tx" : "rx", cyc, bound);
      end
   endtask

   initial begin
      int n, t0, sum;

      rst = 1'b1; enable = 1'b0; div_valid = 1'b0;
      div_value = '0; div_frac = '0;

      tbl[0]  = '{3'b100, 16'd0, 4'b0001};
      tbl[1]  = '{3'b001, 16'd1, 4'b0001};
      tbl[2]  = '{3'b010, 16'd0, 4'b0011};
      tbl[3]  = '{3'b010, 16'd0, 4'b0011};
      tbl[4]  = '{3'b010, 16'd0, 4'b1011};
      tbl[5]  = '{3'b010, 16'd0, 4'b0011};
      tbl[6]  = '{3'b010, 16'd0, 4'b1011};
      tbl[7]  = '{3'b011, 16'd3, 4'b0010};
      tbl[8]  = '{3'b010, 16'd0, 4'b1010};
      tbl[9]  = '{3'b000, 16'd0, 4'b0001};
      tbl[10] = '{3'b010, 16'd0, 4'b0011};
      tbl[11] = '{3'b010, 16'd0, 4'b0011};
      tbl[12] = '{3'b010, 16'd0, 4'b0011};
      tbl[13] = '{3'b010, 16'd0, 4'b0011};
      tbl[14] = '{3'b010, 16'd0, 4'b1011};
      tbl[15] = '{3'b110, 16'd0, 4'b0001};

      for (int i = 0; i < 16; i++) begin
         {rst, enable, div_valid} = tbl[i].ctl;
         div_value = tbl[i].dv;
         cycle();
         check_val($sformatf("vec%0d", i), 32'({rx_tick, tx_tick, busy, div_ready}),
                   32'(tbl[i].exp));
      end
      rst = 1'b0; enable = 1'b0; div_valid = 1'b0; div_value = '0;

      // Default divisor timing from enable.
      rst = 1'b1; cycle(); rst = 1'b0;
      enable = 1'b1; cycle(); t0 = cyc;
      run_until(1'b0, 100, n);  check_val("first_rx_latency", 32'(n), 32'd27);
      run_until(1'b0, 100, n);  check_val("rx_period_default", 32'(n), 32'd27);
      run_until(1'b1, 1000, n); check_val("first_tx_time", 32'(cyc - t0), 32'd432);

      // Mid-bit divisor load waits for the bit boundary.
      for (int k = 0; k < 3; k++) run_until(1'b0, 100, n);
      div_valid = 1'b1; div_value = 16'd9; cycle(); div_valid = 1'b0;
      check_bit("ready_low_after_load", div_ready, 1'b0);
      run_until(1'b0, 100, n);
      for (int k = 0; k < OS; k++) begin
         run_until(1'b0, 100, n);
         check_val("old_rx_period", 32'(n), 32'd27);
         if (tx_tick) break;
         check_bit("ready_held_low", div_ready, 1'b0);
      end
      check_bit("tx_at_apply", tx_tick, 1'b1);
      check_bit("ready_after_apply", div_ready, 1'b1);
      run_until(1'b0, 100, n);  check_val("new_rx_period", 32'(n), 32'd10);
      run_until(1'b1, 1000, n); check_val("new_tx_rest", 32'(n), 32'd150);

      // Divisor 0 loaded in IDLE.
      enable = 1'b0; cycle();
      div_valid = 1'b1; div_value = 16'd0; cycle(); div_valid = 1'b0;
      enable = 1'b1; cycle();
      run_until(1'b0, 10, n);  check_val("div0_first_rx", 32'(n), 32'd1);
      run_until(1'b1, 100, n); check_val("div0_first_tx_rest", 32'(n), 32'd15);
      run_until(1'b1, 100, n); check_val("div0_tx_period", 32'(n), 32'd16);

      // Dropping enable while PENDING applies the shadow.
      div_valid = 1'b1; div_value = 16'd4; cycle(); div_valid = 1'b0;
      check_bit("pending_ready", div_ready, 1'b0);
      enable = 1'b0; cycle();
      check_bit("drop_busy", busy, 1'b0);
      check_bit("drop_rx", rx_tick, 1'b0);
      check_bit("drop_ready", div_ready, 1'b1);
      repeat (3) begin cycle(); check_bit("idle_no_rx", rx_tick, 1'b0); end
      enable = 1'b1; cycle();
      run_until(1'b0, 20, n); check_val("shadow_applied_rx", 32'(n), 32'd5);

      // Reset mid-PENDING discards the shadow.
      div_valid = 1'b1; div_value = 16'd7; cycle(); div_valid = 1'b0;
      cycle();
      rst = 1'b1; cycle();
      check_val("rst_outputs", 32'({rx_tick, tx_tick, busy, div_ready}), 32'd1);
      rst = 1'b0; enable = 1'b0; cycle();
      enable = 1'b1; cycle();
      run_until(1'b0, 100, n); check_val("post_rst_rx", 32'(n), 32'd27);

      // Fractional divisor span over 16 steady-state rx periods.
      rst = 1'b1; cycle(); rst = 1'b0; enable = 1'b0;
      div_valid = 1'b1; div_value = 16'd9; div_frac = 4'd8; cycle(); div_valid = 1'b0;
      enable = 1'b1; cycle();
      for (int k = 0; k < 4; k++) run_until(1'b0, 100, n);
      sum = 0;
      for (int k = 0; k < 16; k++) begin
         run_until(1'b0, 100, n);
         sum += n;
      end
      check_val("frac_16_rx_span", 32'(sum), 32'(EXP_FRAC_SPAN));

      // Randomized traffic against the model.
      rst = 1'b1; cycle(); rst = 1'b0; enable = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 149) == 0) enable = !enable;
         rst       = ($urandom_range(0, 499) == 0);
         div_valid = ($urandom_range(0, 9) == 0);
         div_value = 16'($urandom_range(0, 5));
         div_frac  = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
